// File: rtl/bus_wait_slave.sv
// Wait-stated single-word bus slave fronting a small flop-based memory.
// Captures a request on cs_/as_, waits WAIT_CYCLES, then pulses rdy_ for one cycle.
module bus_wait_slave #(
  parameter int unsigned DEPTH_LOG2  = 4,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs_,
  input  logic        as_,
  input  logic        rw,
  input  logic [29:0] addr,
  input  logic [31:0] wr_data,
  output logic        rdy_,
  output logic [31:0] rd_data
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK
  } state_e;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic                  rw_q, rw_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  rdy_q, rdy_d;
  logic [31:0]           rdata_q, rdata_d;
  logic [31:0]           mem_q [DEPTH];

  // Upper address bits alias onto the same words.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[29:DEPTH_LOG2];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      rw_q    <= 1'b0;
      wdata_q <= '0;
      rdy_q   <= 1'b1;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rw_q    <= rw_d;
      wdata_q <= wdata_d;
      rdy_q   <= rdy_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rw_d    = rw_q;
    wdata_d = wdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (!cs_ && !as_) begin
          idx_d   = addr[DEPTH_LOG2-1:0];
          rw_d    = rw;
          wdata_d = wr_data;
          if (WAIT_CYCLES > 0) begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_CYCLES - 1);
          end else begin
            state_d = S_ACK;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_ACK;
        else             cnt_d   = cnt_q - 4'd1;
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so rdy_/rd_data line up with ACK.
  always_comb begin
    rdy_d   = 1'b1;
    rdata_d = '0;
    if (state_d == S_ACK) begin
      rdy_d = 1'b0;
      if (rw_d) rdata_d = mem_q[idx_d];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (state_q == S_ACK && !rw_q) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

  assign rdy_    = rdy_q;
  assign rd_data = rdata_q;

endmodule
